// File: rtl/l2_cacheline_adapter.sv
// l2_cacheline_adapter
//   Splits a 256-bit L2 line transfer into BURSTS memory beats of BW = 256/BURSTS bits.
//   L2 side : clk, rst, line_i, line_o, address_i, read_i, write_i, resp_o
//   Mem side: burst_i, burst_o, address_o, read_o, write_o, resp_i
//   Optional: define L2_ADAPTER_PERF_CNT_EN to add read_count_o / write_count_o,
//             32-bit wrapping counts of completed read / write line transfers.
module l2_cacheline_adapter #(
  parameter int BURSTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [255:0]          line_i,
  output logic [255:0]          line_o,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [256/BURSTS-1:0] burst_i,
  output logic [256/BURSTS-1:0] burst_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
`ifdef L2_ADAPTER_PERF_CNT_EN
  ,
  output logic [31:0]           read_count_o,
  output logic [31:0]           write_count_o
`endif
);

  localparam int BW = 256 / BURSTS;
  localparam int CW = (BURSTS > 1) ? $clog2(BURSTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [255:0]    r_wline;
  logic [255:0]    r_line;
  logic [31:0]     r_addr;
  logic            r_read;
  logic            r_write;
  logic            r_resp;
  logic            r_is_read;
  logic            w_last;
`ifdef L2_ADAPTER_PERF_CNT_EN
  logic [31:0]     r_rd_count;
  logic [31:0]     r_wr_count;
`endif

  assign w_last = (r_cnt == CW'(BURSTS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wline   <= '0;
      r_line    <= '0;
      r_addr    <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_resp    <= 1'b0;
      r_is_read <= 1'b0;
`ifdef L2_ADAPTER_PERF_CNT_EN
      r_rd_count <= '0;
      r_wr_count <= '0;
`endif
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Read has priority when both requests are high.
          if (read_i) begin
            r_state   <= S_READ;
            r_addr    <= address_i & ~32'h1F;
            r_cnt     <= '0;
            r_read    <= 1'b1;
            r_is_read <= 1'b1;
          end else if (write_i) begin
            r_state   <= S_WRITE;
            r_addr    <= address_i & ~32'h1F;
            r_wline   <= line_i;
            r_cnt     <= '0;
            r_write   <= 1'b1;
            r_is_read <= 1'b0;
          end
        end
        S_READ: begin
          if (resp_i) begin
            r_line[r_cnt*BW +: BW] <= burst_i;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_write <= 1'b0;
              r_resp  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef L2_ADAPTER_PERF_CNT_EN
          if (r_is_read) r_rd_count <= r_rd_count + 32'd1;
          else           r_wr_count <= r_wr_count + 32'd1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write beat is a live slice of the latched line, so it only moves when cnt does.
  assign burst_o   = r_wline[r_cnt*BW +: BW];
  assign line_o    = r_line;
  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;
`ifdef L2_ADAPTER_PERF_CNT_EN
  assign read_count_o  = r_rd_count;
  assign write_count_o = r_wr_count;
`endif

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
module tb_l2_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
`ifdef L2_ADAPTER_PERF_CNT_EN
  logic [31:0]  read_count_o;
  logic [31:0]  write_count_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  l2_cacheline_adapter #(.BURSTS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef L2_ADAPTER_PERF_CNT_EN
    ,
    .read_count_o  (read_count_o),
    .write_count_o (write_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] R1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] R2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] R3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] R4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] R5 = 64'h5555_0000_0000_0005;
  localparam logic [63:0] R6 = 64'h6666_0000_0000_0006;
  localparam logic [63:0] R7 = 64'h7777_0000_0000_0007;
  localparam logic [63:0] R8 = 64'h8888_0000_0000_0008;
  localparam logic [63:0] W0 = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] W1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] W2 = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] W3 = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] B1 = 64'hB1B1_0000_0000_00B1;
  localparam logic [63:0] B2 = 64'hB2B2_0000_0000_00B2;
  localparam logic [63:0] B3 = 64'hB3B3_0000_0000_00B3;
  localparam logic [63:0] B4 = 64'hB4B4_0000_0000_00B4;

  initial begin
    logic [63:0] wb [4];
    logic [63:0] rd [4];
    wb[0] = W0; wb[1] = W1; wb[2] = W2; wb[3] = W3;

    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;

    // Reset state, before any clock edge.
    #2;
    chk("rst_read_o",    read_o,    0);
    chk("rst_write_o",   write_o,   0);
    chk("rst_resp_o",    resp_o,    0);
    chk("rst_address_o", address_o, 0);
    chk("rst_line_o",    line_o,    0);
    chk("rst_burst_o",   burst_o,   0);
    step();
    rst = 1'b0;
    step();

    // Read from 0x1234, four back-to-back beats.
    address_i = 32'h0000_1234; read_i = 1'b1;
    step();
    chk("rd1_read_o",    read_o,    1);
    chk("rd1_address_o", address_o, 32'h0000_1220);
    rd[0] = R1; rd[1] = R2; rd[2] = R3; rd[3] = R4;
    resp_i = 1'b1;
    address_i = 32'hFFFF_FFFF;   // ignored mid-burst
    for (int i = 0; i < 4; i++) begin
      chk("rd1_no_resp", resp_o, 0);
      chk("rd1_read_held", read_o, 1);
      burst_i = rd[i];
      step();
    end
    chk("rd1_resp_o",    resp_o,    1);
    chk("rd1_read_off",  read_o,    0);
    chk("rd1_line_o",    line_o,    {R4, R3, R2, R1});
    chk("rd1_addr_held", address_o, 32'h0000_1220);
    // resp_i during DONE must not touch the line.
    read_i = 1'b0; burst_i = '1;
    step();
    chk("rd1_resp_pulse_end", resp_o, 0);
    chk("rd1_done_resp_ign",  line_o, {R4, R3, R2, R1});
    resp_i = 1'b0;
    step();

    // Write to 0x8000_0040 with resp_i high every other cycle.
    address_i = 32'h8000_0040; line_i = {W3, W2, W1, W0}; write_i = 1'b1;
    step();
    line_i = '1;   // ignored mid-burst
    chk("wr_address_o", address_o, 32'h8000_0040);
    for (int i = 1; i <= 8; i++) begin
      chk("wr_write_held", write_o, 1);
      chk("wr_burst_o",    burst_o, wb[(i-1)/2]);
      chk("wr_no_resp",    resp_o,  0);
      resp_i = (i % 2 == 0);
      step();
    end
    chk("wr_resp_o",    resp_o,  1);
    chk("wr_write_off", write_o, 0);
    chk("wr_line_hold", line_o,  {R4, R3, R2, R1});
    write_i = 1'b0; resp_i = 1'b0;
    step();
    chk("wr_resp_single", resp_o, 0);
    step();
    chk("wr_idle_resp", resp_o, 0);
    chk("wr_idle_write", write_o, 0);

    // Simultaneous read and write request: read wins.
    address_i = 32'h0000_00FF; read_i = 1'b1; write_i = 1'b1;
    step();
    chk("both_read_o",    read_o,    1);
    chk("both_address_o", address_o, 32'h0000_00E0);
    rd[0] = R5; rd[1] = R6; rd[2] = R7; rd[3] = R8;
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("both_write_low", write_o, 0);
      burst_i = rd[i];
      step();
    end
    chk("both_resp_o",  resp_o,  1);
    chk("both_write_o", write_o, 0);
    chk("both_line_o",  line_o,  {R8, R7, R6, R5});
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    step();
    step();
`ifdef L2_ADAPTER_PERF_CNT_EN
    chk("perf_rd_2", read_count_o,  2);
    chk("perf_wr_1", write_count_o, 1);
`endif

    // Stray resp_i in IDLE.
    resp_i = 1'b1; burst_i = 64'hDEAD;
    step();
    step();
    chk("stray_line_o",  line_o,  {R8, R7, R6, R5});
    chk("stray_read_o",  read_o,  0);
    chk("stray_write_o", write_o, 0);
    chk("stray_resp_o",  resp_o,  0);
    resp_i = 1'b0;

    // Reset after two read beats abandons the transfer.
    address_i = 32'h0000_4000; read_i = 1'b1;
    step();
    resp_i = 1'b1; burst_i = 64'hA1;
    step();
    burst_i = 64'hA2;
    step();
    chk("mid_read_o", read_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_read_o",    read_o,    0);
    chk("arst_line_o",    line_o,    0);
    chk("arst_address_o", address_o, 0);
    chk("arst_resp_o",    resp_o,    0);
    read_i = 1'b0; resp_i = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_no_resp", resp_o, 0);
    end

    // Fresh read after reset starts at beat 0.
    address_i = 32'h0000_4010; read_i = 1'b1;
    step();
    resp_i = 1'b1; burst_i = B1;
    step();
    chk("post_rst_beat0", line_o, {192'd0, B1});
    rd[0] = B1; rd[1] = B2; rd[2] = B3; rd[3] = B4;
    for (int i = 1; i < 4; i++) begin
      burst_i = rd[i];
      step();
    end
    chk("post_rst_resp_o", resp_o, 1);
    chk("post_rst_line_o", line_o, {B4, B3, B2, B1});
    read_i = 1'b0; resp_i = 1'b0;
    step();
    chk("post_rst_resp_end", resp_o, 0);
    step();
`ifdef L2_ADAPTER_PERF_CNT_EN
    chk("perf_rd_after_rst", read_count_o,  1);
    chk("perf_wr_after_rst", write_count_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
